div_12: RTL and testbench

DIV_12 -- requirements
Module: div_12

---
 rtl/div_12.sv | 105 ++++++++++
 tb/tb_div_12.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/div_12.sv
// 12-bit float divider (1/5/6, bias 15): 8-step restoring mantissa divide, then normalise/range.
// Latency 9 cycles from accept to valid_o; ready_o low while busy, valid_i ignored then.
module div_12 (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [11:0] data_1_i,
   input  logic [11:0] data_2_i,
   output logic        valid_o,
   output logic [11:0] data_div_o,
   output logic        div_by_zero_o
);

   typedef enum logic [1:0] {IDLE, CALC, NORM} state_t;

   state_t             r_state;
   logic [2:0]         r_cnt;
   logic [7:0]         r_rem;
   logic [6:0]         r_div;
   logic [7:0]         r_q;
   logic signed [6:0]  r_exp;
   logic               r_sign;
   logic               r_a_zero;
   logic               r_b_zero;
   logic               r_valid;
   logic [11:0]        r_data;
   logic               r_dbz;

   logic               w_accept;
   logic               w_ge;
   logic [6:0]         w_sub;
   logic signed [6:0]  w_exp_n;
   logic [5:0]         w_mant;

   assign ready_o       = (r_state == IDLE);
   assign w_accept      = valid_i & ready_o;
   assign valid_o       = r_valid;
   assign data_div_o    = r_data;
   assign div_by_zero_o = r_dbz;

   // Remainder minus divisor is always below the divisor here, so 7 bits suffice.
   assign w_ge    = (r_rem >= {1'b0, r_div});
   assign w_sub   = r_rem[6:0] - r_div;
   assign w_exp_n = r_q[7] ? r_exp : (r_exp - 7'sd1);
   assign w_mant  = r_q[7] ? r_q[6:1] : r_q[5:0];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state  <= IDLE;
         r_cnt    <= 3'd0;
         r_rem    <= 8'd0;
         r_div    <= 7'd0;
         r_q      <= 8'd0;
         r_exp    <= 7'sd0;
         r_sign   <= 1'b0;
         r_a_zero <= 1'b0;
         r_b_zero <= 1'b0;
         r_valid  <= 1'b0;
         r_data   <= 12'h000;
         r_dbz    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state  <= CALC;
                  r_cnt    <= 3'd7;
                  r_rem    <= {2'b01, data_1_i[5:0]};
                  r_div    <= {1'b1, data_2_i[5:0]};
                  r_q      <= 8'd0;
                  r_exp    <= $signed({2'b00, data_1_i[10:6]} - {2'b00, data_2_i[10:6]} + 7'd15);
                  r_sign   <= data_1_i[11] ^ data_2_i[11];
                  r_a_zero <= (data_1_i[10:0] == 11'd0);
                  r_b_zero <= (data_2_i[10:0] == 11'd0);
               end
            end
            CALC: begin
               r_q <= {r_q[6:0], w_ge};
               if (w_ge) r_rem <= {w_sub, 1'b0};
               else      r_rem <= {r_rem[6:0], 1'b0};
               if (r_cnt == 3'd0) r_state <= NORM;
               else               r_cnt   <= r_cnt - 3'd1;
            end
            NORM: begin
               r_state <= IDLE;
               r_valid <= 1'b1;
               r_dbz   <= r_b_zero;
               if (r_b_zero)
                  r_data <= {r_sign, 5'd31, 6'h3F};
               else if (r_a_zero)
                  r_data <= 12'h000;
               else if (w_exp_n >= 7'sd31)
                  r_data <= {r_sign, 5'd31, 6'h3F};
               else if (w_exp_n <= 7'sd0)
                  r_data <= 12'h000;
               else
                  r_data <= {r_sign, w_exp_n[4:0], w_mant};
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_12.sv
// Directed bench for div_12: hand-computed quotients, latency, handshake and mid-op reset.
module tb_div_12;

   logic        clk_i;
   logic        rst_n_i;
   logic        valid_i;
   logic        ready_o;
   logic [11:0] data_1_i;
   logic [11:0] data_2_i;
   logic        valid_o;
   logic [11:0] data_div_o;
   logic        div_by_zero_o;

   int n_vec;
   int n_err;

   div_12 dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .data_1_i      (data_1_i),
      .data_2_i      (data_2_i),
      .valid_o       (valid_o),
      .data_div_o    (data_div_o),
      .div_by_zero_o (div_by_zero_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called #1 after a rising edge; accept happens on the next edge.
   task automatic do_op(input string tag, input logic [11:0] a, input logic [11:0] b,
                        input logic [11:0] e_q, input logic e_z);
      chk({tag, ".ready"}, {11'd0, ready_o}, 12'd1);
      valid_i  = 1'b1;
      data_1_i = a;
      data_2_i = b;
      @(posedge clk_i); #1;
      valid_i  = 1'b0;
      data_1_i = 12'hABC;
      data_2_i = 12'h123;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk_i); #1;
         chk({tag, ".valid"}, {11'd0, valid_o}, (k == 9) ? 12'd1 : 12'd0);
      end
      chk({tag, ".data"}, data_div_o, e_q);
      chk({tag, ".dbz"}, {11'd0, div_by_zero_o}, {11'd0, e_z});
      chk({tag, ".ready_in_valid"}, {11'd0, ready_o}, 12'd1);
      @(posedge clk_i); #1;
      chk({tag, ".valid_drop"}, {11'd0, valid_o}, 12'd0);
      chk({tag, ".hold"}, data_div_o, e_q);
   endtask

   logic [11:0] tbl_a [0:19];
   logic [11:0] tbl_b [0:19];
   int          n_pulse;

   initial begin
      n_vec    = 0;
      n_err    = 0;
      valid_i  = 1'b0;
      data_1_i = 12'h000;
      data_2_i = 12'h000;
      rst_n_i  = 1'b1;
      #2 rst_n_i = 1'b0;
      #1;
      chk("rst.valid", {11'd0, valid_o}, 12'd0);
      chk("rst.data", data_div_o, 12'h000);
      chk("rst.dbz", {11'd0, div_by_zero_o}, 12'd0);
      chk("rst.ready", {11'd0, ready_o}, 12'd1);
      @(posedge clk_i); @(posedge clk_i); #3;
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;

      do_op("norm_1_over_1p5", 12'h3C0, 12'h3E0, 12'h395, 1'b0);
      do_op("neg3_over_2",     12'hC20, 12'h400, 12'hBE0, 1'b0);
      do_op("2_over_1",        12'h400, 12'h3C0, 12'h400, 1'b0);
      do_op("saturate",        12'h7C0, 12'h040, 12'h7FF, 1'b0);
      do_op("underflow",       12'h040, 12'h7C0, 12'h000, 1'b0);
      do_op("div_zero_negb",   12'h3C0, 12'h800, 12'hFFF, 1'b1);
      do_op("zero_over_zero",  12'h000, 12'h000, 12'h7FF, 1'b1);
      do_op("zero_dividend",   12'h000, 12'h3C0, 12'h000, 1'b0);
      do_op("negzero_divd",    12'h800, 12'h3C0, 12'h000, 1'b0);

      // valid_i held high for 20 edges with fresh data each cycle
      for (int i = 0; i < 20; i++) begin
         tbl_a[i] = 12'h7C0 - 12'(i);
         tbl_b[i] = 12'h041 + 12'(i);
      end
      tbl_a[0]  = 12'h3C0; tbl_b[0]  = 12'h3E0;
      tbl_a[10] = 12'hC20; tbl_b[10] = 12'h400;
      n_pulse  = 0;
      valid_i  = 1'b1;
      data_1_i = tbl_a[0];
      data_2_i = tbl_b[0];
      for (int c = 0; c < 22; c++) begin
         @(posedge clk_i); #1;
         if (c < 19) begin
            data_1_i = tbl_a[c + 1];
            data_2_i = tbl_b[c + 1];
         end else begin
            valid_i = 1'b0;
         end
         chk("hs.valid", {11'd0, valid_o}, (c == 9 || c == 19) ? 12'd1 : 12'd0);
         if (valid_o) begin
            n_pulse++;
            chk("hs.data", data_div_o, (c == 9) ? 12'h395 : 12'hBE0);
         end
      end
      chk("hs.count", 12'(n_pulse), 12'd2);

      // reset in the middle of CALC
      valid_i  = 1'b1;
      data_1_i = 12'h400;
      data_2_i = 12'h3C0;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      @(posedge clk_i); @(posedge clk_i); @(posedge clk_i); #3;
      rst_n_i = 1'b0;
      #1;
      chk("mid.valid", {11'd0, valid_o}, 12'd0);
      chk("mid.data", data_div_o, 12'h000);
      chk("mid.dbz", {11'd0, div_by_zero_o}, 12'd0);
      chk("mid.ready", {11'd0, ready_o}, 12'd1);
      @(posedge clk_i); @(posedge clk_i); #3;
      rst_n_i = 1'b1;
      n_pulse = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk_i); #1;
         if (valid_o) n_pulse++;
      end
      chk("mid.no_valid", 12'(n_pulse), 12'd0);
      do_op("after_reset", 12'hC20, 12'h400, 12'hBE0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
